// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared constants for the add/sub round-robin arbiter slice.
package addsub_rr_arbiter_pkg;

    // Datapath width of the shared adder/subtractor
    localparam int unsigned DATA_W = 4;

    // Result buffer state encoding
    localparam logic BUF_EMPTY = 1'b0;
    localparam logic BUF_FULL  = 1'b1;

    // Requester identifiers
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request/response handshake bundle between requesters, consumer and the arbiter.
interface addsub_rr_arbiter_if;
    import addsub_rr_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_sub;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_sub;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_cout;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_cout,
        output resp_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_cout,
        input  resp_ready
    );

endinterface

// File: rtl/addsub_rr_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer breaks ties, grants gated by can_accept.
module addsub_rr_arbiter_rr_arbiter2
    import addsub_rr_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    input  logic       can_accept,
    output logic [1:0] grant,
    output logic       winner
);

    // Pick the winner, then grant it only when the buffer can take a result
    always_comb begin
        winner = REQ0;
        if (valid0 && valid1) begin
            winner = ptr;
        end else if (valid1) begin
            winner = REQ1;
        end
        grant = 2'b00;
        if (can_accept) begin
            grant[0] = valid0 && (winner == REQ0);
            grant[1] = valid1 && (winner == REQ1);
        end
    end

endmodule

// File: rtl/four_bit_adder_subtractor.sv
// 4-bit adder/subtractor; subtraction adds the two's complement of b.
module four_bit_adder_subtractor
    import addsub_rr_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W-1:0] addend;

    // b = 0 in subtract wraps the addend to 0, so cout stays 0
    always_comb begin
        addend          = sub ? (~b + DATA_W'(1)) : b;
        {cout, result}  = {1'b0, a} + {1'b0, addend};
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one adder/subtractor between two requesters with a one-entry result buffer.
module addsub_rr_arbiter
    import addsub_rr_arbiter_pkg::*;
#(
    parameter int unsigned START_PRIO = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_rr_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   ops_done
);

    logic              state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              cout_q, cout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              can_accept;
    logic              accept;
    logic              consume;
    logic              winner;
    logic [1:0]        grant;
    logic [DATA_W-1:0] op_a, op_b, dp_result;
    logic              op_sub, dp_cout;

    // Readies are held low during reset so nothing is accepted then
    assign can_accept = rst_n && ((state_q == BUF_EMPTY) || bus.resp_ready);
    assign consume    = (state_q == BUF_FULL) && bus.resp_ready;
    assign accept     = |grant;

    addsub_rr_arbiter_rr_arbiter2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .ptr        (ptr_q),
        .can_accept (can_accept),
        .grant      (grant),
        .winner     (winner)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // Operand mux steered by the arbitration winner
    always_comb begin
        op_a   = bus.req0_a;
        op_b   = bus.req0_b;
        op_sub = bus.req0_sub;
        if (winner == REQ1) begin
            op_a   = bus.req1_a;
            op_b   = bus.req1_b;
            op_sub = bus.req1_sub;
        end
    end

    four_bit_adder_subtractor u_dp (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (dp_result),
        .cout   (dp_cout)
    );

    // Next state: load on accept (even while draining), empty on a bare consume
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d  = BUF_FULL;
            ptr_d    = ~winner;
            id_d     = winner;
            result_d = dp_result;
            cout_d   = dp_cout;
        end else if (consume) begin
            state_d = BUF_EMPTY;
        end
        if (consume) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BUF_EMPTY;
            ptr_q    <= 1'(START_PRIO);
            id_q     <= REQ0;
            result_q <= '0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.resp_valid  = (state_q == BUF_FULL);
    assign bus.resp_id     = id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_cout   = cout_q;
    assign ops_done        = cnt_q;

endmodule
